// File: rtl/fetch_pkg.sv
// Shared definitions for the BRAM fetch arbiter: FSM state encoding and
// parameter defaults used by bram_fetch_arbiter and its testbench.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 256;
  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_LEN_WIDTH  = 10;
  localparam int unsigned DEF_RD_LATENCY = 1;

  // Drain counter must hold RD_LATENCY-1 for the largest supported latency (4).
  localparam int unsigned DRAIN_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first set request at or after prio_ptr.
// Ports:
//   req        - request vector
//   prio_ptr   - index where the search starts
//   grant_c    - one-hot grant (combinational, zero when no request)
//   grant_idx_c- index of the granted requester (combinational)
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] prio_ptr,
  output logic [NUM_REQ-1:0]  grant_c,
  output logic [ID_WIDTH-1:0] grant_idx_c
);

  logic        found;
  int unsigned j;

  // Walk the ring starting at prio_ptr; the first hit wins.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    j           = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(prio_ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found       = 1'b1;
        grant_c     = NUM_REQ'(1) << j;
        grant_idx_c = ID_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/bram_fetch_arbiter.sv
// Burst fetch arbiter: grants one of NUM_REQ requesters round-robin, issues
// len consecutive BRAM reads, then drains the read pipeline before idling.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/addr/len- per-requester burst requests (flattened slices)
//   req_ready         - one-cycle accept pulse (combinational, in IDLE)
//   bram_en/bram_addr - BRAM read port
//   bram_rdata        - BRAM read data, RD_LATENCY cycles after bram_en
//   rdata/_valid/_id  - returned data, qualifier and owner
//   burst_done        - one-hot pulse with the last rdata_valid of a burst
//   busy              - high outside IDLE
module bram_fetch_arbiter
  import fetch_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter  int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter  int unsigned RD_LATENCY = DEF_RD_LATENCY,
  localparam int unsigned ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          bram_en,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [DATA_WIDTH-1:0]         bram_rdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rdata_valid,
  output logic [ID_WIDTH-1:0]           rdata_id,
  output logic [NUM_REQ-1:0]            burst_done,
  output logic                          busy
);

  fetch_state_e             state, state_nxt;
  logic [ID_WIDTH-1:0]      prio_ptr, prio_ptr_nxt;
  logic [ADDR_WIDTH-1:0]    base_addr, base_nxt;
  logic [LEN_WIDTH-1:0]     burst_len, len_nxt;
  logic [LEN_WIDTH-1:0]     offset, offset_nxt;
  logic [ID_WIDTH-1:0]      burst_id, id_nxt;
  logic [DRAIN_CNT_W-1:0]   drain_cnt, drain_cnt_nxt;
  logic [NUM_REQ-1:0]       grant_c;
  logic [ID_WIDTH-1:0]      grant_idx_c;
  logic [RD_LATENCY-1:0]    vld_pipe;
  logic [ID_WIDTH-1:0]      id_pipe [RD_LATENCY];

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req         (req_valid),
    .prio_ptr    (prio_ptr),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  // State and burst context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      base_addr <= '0;
      burst_len <= '0;
      offset    <= '0;
      burst_id  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      prio_ptr  <= prio_ptr_nxt;
      base_addr <= base_nxt;
      burst_len <= len_nxt;
      offset    <= offset_nxt;
      burst_id  <= id_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt     = state;
    prio_ptr_nxt  = prio_ptr;
    base_nxt      = base_addr;
    len_nxt       = burst_len;
    offset_nxt    = offset;
    id_nxt        = burst_id;
    drain_cnt_nxt = drain_cnt;
    req_ready     = '0;
    bram_en       = 1'b0;
    bram_addr     = '0;
    burst_done    = '0;
    busy          = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        // rst gating keeps req_ready quiet while reset is held.
        if (|req_valid && !rst) begin
          req_ready = grant_c;
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_c[k]) begin
              base_nxt = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
              len_nxt  = req_len[k*LEN_WIDTH +: LEN_WIDTH];
            end
          end
          id_nxt        = grant_idx_c;
          offset_nxt    = '0;
          drain_cnt_nxt = '0;
          prio_ptr_nxt  = (32'(grant_idx_c) == NUM_REQ - 1) ? '0 : grant_idx_c + 1'b1;
          state_nxt     = BURST;
        end
      end

      BURST: begin
        if (burst_len == '0) begin
          // Zero-length burst: nothing is read, complete right away.
          burst_done = NUM_REQ'(1) << burst_id;
          state_nxt  = IDLE;
        end else begin
          bram_en   = 1'b1;
          bram_addr = base_addr + ADDR_WIDTH'(offset);
          if (offset == burst_len - 1'b1) begin
            drain_cnt_nxt = '0;
            state_nxt     = DRAIN;
          end else begin
            offset_nxt = offset + 1'b1;
          end
        end
      end

      DRAIN: begin
        // Last drain cycle is when the final word leaves the read pipeline.
        if (32'(drain_cnt) == RD_LATENCY - 1) begin
          burst_done = NUM_REQ'(1) << burst_id;
          state_nxt  = IDLE;
        end else begin
          drain_cnt_nxt = drain_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read-return pipeline aligned to the BRAM latency; reset drops in-flight words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) id_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= bram_en;
      id_pipe[0]  <= burst_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign rdata_valid = vld_pipe[RD_LATENCY-1];
  assign rdata_id    = id_pipe[RD_LATENCY-1];
  assign rdata       = bram_rdata;

endmodule
